// File: rtl/beacon_scheduler_if.sv
// Beacon scheduler handshake bundle: pass-window enable, packetizer
// req/ack, sequence number, failure count and activity flag.
// The fail_cnt signal exists only when BEACON_FAIL_CNT_EN is defined.
interface beacon_scheduler_if;
    logic       tx_enable;
    logic       tx_ack;
    logic       tx_req;
    logic [7:0] pkt_seq;
    logic       active;
`ifdef BEACON_FAIL_CNT_EN
    logic [7:0] fail_cnt;
`endif

    // Scheduler side: consumes the window enable and the ack, drives the request
    modport master (
        input  tx_enable,
        input  tx_ack,
        output tx_req,
        output pkt_seq,
`ifdef BEACON_FAIL_CNT_EN
        output fail_cnt,
`endif
        output active
    );

    // Window controller / packetizer side
    modport slave (
        output tx_enable,
        output tx_ack,
        input  tx_req,
        input  pkt_seq,
`ifdef BEACON_FAIL_CNT_EN
        input  fail_cnt,
`endif
        input  active
    );
endinterface

// File: rtl/beacon_scheduler.sv
// Beacon scheduler: while the pass window is open, requests a beacon every
// PERIOD_TICKS clocks over a req/ack handshake, with ack timeout and bounded
// retries. Optional abandoned-packet counter enabled by BEACON_FAIL_CNT_EN.
module beacon_scheduler #(
    parameter int unsigned PERIOD_TICKS = 50,
    parameter int unsigned ACK_TIMEOUT  = 20,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               reset,
    beacon_scheduler_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        WAIT    = 2'd3
    } state_t;

    localparam logic [13:0] PER_LAST = 14'(PERIOD_TICKS - 1);
    localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [13:0] period_q, period_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  seq_q, seq_d;
    logic        req_q, req_d;
    logic        active_q, active_d;
`ifdef BEACON_FAIL_CNT_EN
    logic [7:0]  fail_q, fail_d;
`endif

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        seq_d    = seq_q;
`ifdef BEACON_FAIL_CNT_EN
        fail_d   = fail_q;
`endif
        if (state_q != IDLE && !bus.tx_enable) begin
            // Window closed: drop any pending request silently
            state_d  = IDLE;
            period_d = '0;
            tmo_d    = '0;
            retry_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.tx_enable) begin
                        state_d = REQ;
                        tmo_d   = '0;
                    end
                end
                REQ: begin
                    if (bus.tx_ack) begin
                        // Ack takes priority over a coincident timeout
                        state_d  = WAIT;
                        seq_d    = seq_q + 8'd1;
                        retry_d  = '0;
                        period_d = '0;
                        tmo_d    = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = BACKOFF;
                        end else begin
                            state_d  = WAIT;
                            seq_d    = seq_q + 8'd1;
                            retry_d  = '0;
                            period_d = '0;
`ifdef BEACON_FAIL_CNT_EN
                            if (fail_q != 8'hFF) begin
                                fail_d = fail_q + 8'd1;
                            end
`endif
                        end
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                BACKOFF: begin
                    state_d = REQ;
                    tmo_d   = '0;
                end
                WAIT: begin
                    if (period_q == PER_LAST) begin
                        state_d  = REQ;
                        tmo_d    = '0;
                        period_d = '0;
                    end else begin
                        period_d = period_q + 14'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // Outputs are registered from the next state so they align with it
        req_d    = (state_d == REQ);
        active_d = (state_d != IDLE);
    end

    // State, counters and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            period_q <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            seq_q    <= '0;
            req_q    <= 1'b0;
            active_q <= 1'b0;
`ifdef BEACON_FAIL_CNT_EN
            fail_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            seq_q    <= seq_d;
            req_q    <= req_d;
            active_q <= active_d;
`ifdef BEACON_FAIL_CNT_EN
            fail_q   <= fail_d;
`endif
        end
    end

    assign bus.tx_req  = req_q;
    assign bus.pkt_seq = seq_q;
    assign bus.active  = active_q;
`ifdef BEACON_FAIL_CNT_EN
    assign bus.fail_cnt = fail_q;
`endif

endmodule

// File: tb/tb_beacon_scheduler.sv
// Directed bench for beacon_scheduler with PERIOD_TICKS=5, ACK_TIMEOUT=4,
// MAX_RETRY=2. fail_cnt checks are present only with BEACON_FAIL_CNT_EN.
module tb_beacon_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    beacon_scheduler_if bif ();

    beacon_scheduler #(
        .PERIOD_TICKS (5),
        .ACK_TIMEOUT  (4),
        .MAX_RETRY    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        bif.tx_enable = 1'b0;
        bif.tx_ack    = 1'b0;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        step();
    endtask

    // Wait (bounded) for a request, then ack it for one cycle
    task automatic do_acks(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!bif.tx_req && w < 30) begin
                step();
                w++;
            end
            total++;
            if (!bif.tx_req) begin
                bad++;
                $display("FAIL ack_wait: tx_req=%0b want 1 within 30 cycles", bif.tx_req);
                return;
            end
            bif.tx_ack = 1'b1;
            step();
            bif.tx_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        bif.tx_enable = 1'b0;
        bif.tx_ack    = 1'b0;
        #1 reset = 1'b0;
        #1;
        total++;
        if (bif.tx_req !== 1'b0 || bif.active !== 1'b0 || bif.pkt_seq !== 8'd0) begin
            bad++;
            $display("FAIL reset: req=%b active=%b seq=%0d want 0 0 0", bif.tx_req, bif.active, bif.pkt_seq);
        end
`ifdef BEACON_FAIL_CNT_EN
        total++;
        if (bif.fail_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_fail: fail_cnt=%0d want 0", bif.fail_cnt);
        end
`endif
        #5 reset = 1'b1;
        step();
    endtask

    task automatic test_period();
        bif.tx_enable = 1'b1;
        step();
        total++;
        if (bif.tx_req !== 1'b1 || bif.active !== 1'b1) begin
            bad++;
            $display("FAIL first_req: req=%b active=%b want 1 1", bif.tx_req, bif.active);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bif.tx_req !== 1'b1 || bif.pkt_seq !== 8'(k)) begin
                bad++;
                $display("FAIL period_req k=%0d: req=%b seq=%0d want 1 %0d", k, bif.tx_req, bif.pkt_seq, k);
            end
            step();
            bif.tx_ack = 1'b1;
            step();
            bif.tx_ack = 1'b0;
            total++;
            if (bif.tx_req !== 1'b0 || bif.pkt_seq !== 8'(k + 1)) begin
                bad++;
                $display("FAIL period_ack k=%0d: req=%b seq=%0d want 0 %0d", k, bif.tx_req, bif.pkt_seq, k + 1);
            end
            for (int i = 0; i < 4; i++) begin
                step();
                total++;
                if (bif.tx_req !== 1'b0) begin
                    bad++;
                    $display("FAIL period_gap k=%0d i=%0d: req=%b want 0", k, i, bif.tx_req);
                end
            end
            step();
            total++;
            if (bif.tx_req !== 1'b1) begin
                bad++;
                $display("FAIL period_rise k=%0d: req=%b want 1", k, bif.tx_req);
            end
        end
    endtask

    task automatic test_reset_mid();
        // In REQ with seq 3 here
        #3 reset = 1'b0;
        #1;
        total++;
        if (bif.tx_req !== 1'b0 || bif.active !== 1'b0 || bif.pkt_seq !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: req=%b active=%b seq=%0d want 0 0 0", bif.tx_req, bif.active, bif.pkt_seq);
        end
        bif.tx_enable = 1'b0;
        #3 reset = 1'b1;
        step();
    endtask

    task automatic test_abandon();
        logic [15:0] pat;
        pat = 16'b0111_1011_1101_1110;
        restart();
        bif.tx_enable = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            total++;
            if (bif.tx_req !== pat[c] || bif.pkt_seq !== ((c == 15) ? 8'd1 : 8'd0)) begin
                bad++;
                $display("FAIL abandon_wave c=%0d: req=%b seq=%0d want %b %0d", c, bif.tx_req, bif.pkt_seq, pat[c], (c == 15) ? 1 : 0);
            end
        end
        total++;
        if (bif.active !== 1'b1) begin
            bad++;
            $display("FAIL abandon_active: active=%b want 1", bif.active);
        end
`ifdef BEACON_FAIL_CNT_EN
        total++;
        if (bif.fail_cnt !== 8'd1) begin
            bad++;
            $display("FAIL abandon_fail: fail_cnt=%0d want 1", bif.fail_cnt);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bif.tx_req !== 1'b0) begin
                bad++;
                $display("FAIL abandon_wait i=%0d: req=%b want 0", i, bif.tx_req);
            end
        end
        step();
        total++;
        if (bif.tx_req !== 1'b1 || bif.pkt_seq !== 8'd1) begin
            bad++;
            $display("FAIL abandon_next: req=%b seq=%0d want 1 1", bif.tx_req, bif.pkt_seq);
        end
    endtask

    task automatic test_ack_at_timeout();
        restart();
        bif.tx_enable = 1'b1;
        repeat (4) step();
        bif.tx_ack = 1'b1;
        step();
        bif.tx_ack = 1'b0;
        total++;
        if (bif.tx_req !== 1'b0 || bif.pkt_seq !== 8'd1) begin
            bad++;
            $display("FAIL ack_tmo: req=%b seq=%0d want 0 1", bif.tx_req, bif.pkt_seq);
        end
`ifdef BEACON_FAIL_CNT_EN
        total++;
        if (bif.fail_cnt !== 8'd0) begin
            bad++;
            $display("FAIL ack_tmo_fail: fail_cnt=%0d want 0", bif.fail_cnt);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bif.tx_req !== 1'b0) begin
                bad++;
                $display("FAIL ack_tmo_gap i=%0d: req=%b want 0", i, bif.tx_req);
            end
        end
        step();
        total++;
        if (bif.tx_req !== 1'b1 || bif.pkt_seq !== 8'd1) begin
            bad++;
            $display("FAIL ack_tmo_next: req=%b seq=%0d want 1 1", bif.tx_req, bif.pkt_seq);
        end
    endtask

    task automatic test_enable_drop();
        restart();
        bif.tx_enable = 1'b1;
        do_acks(7);
        repeat (6) step();
        total++;
        if (bif.tx_req !== 1'b1 || bif.pkt_seq !== 8'd7) begin
            bad++;
            $display("FAIL drop_pre: req=%b seq=%0d want 1 7", bif.tx_req, bif.pkt_seq);
        end
        bif.tx_enable = 1'b0;
        step();
        total++;
        if (bif.tx_req !== 1'b0 || bif.active !== 1'b0 || bif.pkt_seq !== 8'd7) begin
            bad++;
            $display("FAIL drop: req=%b active=%b seq=%0d want 0 0 7", bif.tx_req, bif.active, bif.pkt_seq);
        end
        bif.tx_enable = 1'b1;
        step();
        total++;
        if (bif.tx_req !== 1'b1 || bif.active !== 1'b1 || bif.pkt_seq !== 8'd7) begin
            bad++;
            $display("FAIL drop_reenable: req=%b active=%b seq=%0d want 1 1 7", bif.tx_req, bif.active, bif.pkt_seq);
        end
    endtask

    task automatic test_seq_wrap();
        do_acks(248);
        repeat (6) step();
        total++;
        if (bif.tx_req !== 1'b1 || bif.pkt_seq !== 8'd255) begin
            bad++;
            $display("FAIL wrap_pre: req=%b seq=%0d want 1 255", bif.tx_req, bif.pkt_seq);
        end
        bif.tx_ack = 1'b1;
        step();
        bif.tx_ack = 1'b0;
        total++;
        if (bif.pkt_seq !== 8'd0) begin
            bad++;
            $display("FAIL wrap: seq=%0d want 0", bif.pkt_seq);
        end
    endtask

    task automatic test_fail_sat();
        // Abandonment k lands on edge 15 + 19*(k-1) after enable
        restart();
        bif.tx_enable = 1'b1;
        for (int e = 1; e <= 4861; e++) begin
            step();
            if (e == 186) begin
                total++;
                if (bif.pkt_seq !== 8'd10) begin
                    bad++;
                    $display("FAIL sat_seq10: seq=%0d want 10", bif.pkt_seq);
                end
`ifdef BEACON_FAIL_CNT_EN
                total++;
                if (bif.fail_cnt !== 8'd10) begin
                    bad++;
                    $display("FAIL sat_fail10: fail_cnt=%0d want 10", bif.fail_cnt);
                end
`endif
            end
            if (e == 4841) begin
                total++;
                if (bif.pkt_seq !== 8'd255) begin
                    bad++;
                    $display("FAIL sat_seq255: seq=%0d want 255", bif.pkt_seq);
                end
`ifdef BEACON_FAIL_CNT_EN
                total++;
                if (bif.fail_cnt !== 8'd255) begin
                    bad++;
                    $display("FAIL sat_fail255: fail_cnt=%0d want 255", bif.fail_cnt);
                end
`endif
            end
            if (e == 4861) begin
                total++;
                if (bif.pkt_seq !== 8'd0 || bif.tx_req !== 1'b0) begin
                    bad++;
                    $display("FAIL sat_seq256: seq=%0d req=%b want 0 0", bif.pkt_seq, bif.tx_req);
                end
`ifdef BEACON_FAIL_CNT_EN
                total++;
                if (bif.fail_cnt !== 8'd255) begin
                    bad++;
                    $display("FAIL sat_hold: fail_cnt=%0d want 255", bif.fail_cnt);
                end
`endif
            end
        end
    endtask

    initial begin
        bif.tx_enable = 1'b0;
        bif.tx_ack    = 1'b0;
        test_reset();
        test_period();
        test_reset_mid();
        test_abandon();
        test_ack_at_timeout();
        test_enable_drop();
        test_seq_wrap();
        test_fail_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beacon_scheduler.md
Name: beacon_scheduler

Overview:
- Downstream consumer of the orbit pass-window controller's tx_enable.
- While the window is open, it requests a beacon packet from the radio packetizer every PERIOD_TICKS clocks over a req/ack handshake.
- Missing acks are timed out and retried with bounds; a per-packet sequence number and a failure count are maintained.
- Runs on the same 10 Hz system tick clock as the window controller.

Parameters:
- PERIOD_TICKS, 50, clocks from accepted beacon to next request (5 s at 10 Hz); legal range 2..16383
- ACK_TIMEOUT, 20, clocks tx_req may stay high without tx_ack before the attempt fails; legal range 1..255
- MAX_RETRY, 3, retries after the first failed attempt before the packet is abandoned; legal range 0..15

Ports:
- clk  input  1  system tick clock (10 Hz)
- reset  input  1  asynchronous, active-low reset
- tx_enable  input  1  pass window open, synchronous to clk
- tx_ack  input  1  packetizer accepted current request; single-cycle pulse
- tx_req  output  1  beacon request to packetizer; level, held until ack/timeout
- pkt_seq  output  8  sequence number of the packet currently/next requested
- fail_cnt  output  8  abandoned-packet count, saturating (BEACON_FAIL_CNT_EN only)
- active  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (reset==0, async): state IDLE; tx_req=0, pkt_seq=0, fail_cnt=0, active=0; period, timeout and retry counters cleared.
- All outputs are registered.
- States: IDLE, REQ, BACKOFF, WAIT.
- IDLE:
  - tx_enable=1 at an edge -> REQ next cycle.
  - The first beacon of a window is requested immediately, with no period delay.
- REQ:
  - tx_req=1; the timeout counter increments each cycle from 0.
  - tx_ack=1 -> WAIT; tx_req drops next cycle; pkt_seq+1 (wraps 255->0); retry and period counters cleared.
  - Timeout counter reaches ACK_TIMEOUT-1 with no ack, and retry<MAX_RETRY -> retry+1, go BACKOFF.
  - Same timeout with retry==MAX_RETRY -> packet abandoned: pkt_seq+1, fail_cnt+1 (saturates at 255), retry cleared, go WAIT.
  - tx_ack in the same cycle as the timeout -> the ack wins; no retry, no fail count.
- BACKOFF:
  - Exactly one cycle with tx_req=0, then REQ with the timeout counter cleared.
  - The packetizer must always see a req deassertion between attempts.
  - pkt_seq is unchanged across retries.
- WAIT:
  - The period counter counts 0..PERIOD_TICKS-1.
  - On the terminal count -> REQ.
  - The period is therefore PERIOD_TICKS clocks from the ack (or abandonment) edge to the tx_req rise.
- tx_ack outside REQ is ignored.
- tx_enable=0 in any non-IDLE state -> IDLE next edge:
  - tx_req=0 on that edge.
  - A pending request is dropped without counting as a failure; pkt_seq is not incremented.
  - Period, timeout and retry counters cleared.
  - pkt_seq and fail_cnt persist across windows; only reset clears them.
- tx_enable reasserting the cycle after a drop -> normal IDLE->REQ entry.
- Counter widths:
  - period counter 14 bits (covers the 4800-tick window)
  - timeout counter 8 bits
  - retry counter 4 bits
  - No counter may wrap; each stops at its terminal value.
- active = (state != IDLE).

Optional Feature:
- Macro: BEACON_FAIL_CNT_EN.
- Defined: the fail_cnt port and its 8-bit saturating counter exist as described above.
- Undefined:
  - The fail_cnt port and its register are absent.
  - Abandonment still increments pkt_seq and returns to WAIT.
  - All other behaviour is identical.

Test Plan:
- Reset mid-REQ with tx_req=1 -> tx_req, active and pkt_seq are 0 immediately, without waiting for a clock edge.
- PERIOD_TICKS=5, tx_enable held 1, tx_ack returned 2 cycles after each tx_req rise -> tx_req rises at cycle 1, then exactly 5 cycles after each ack; pkt_seq steps 0,1,2.
- ACK_TIMEOUT=4, MAX_RETRY=2, no ack:
  - 3 req pulses of 4 cycles each, separated by 1-cycle lows.
  - Then fail_cnt=1, pkt_seq=1, state WAIT.
- Ack in the exact timeout cycle of the first attempt -> no BACKOFF; fail_cnt stays 0; pkt_seq=1.
- tx_enable dropped during REQ (seq=7) -> tx_req=0 next edge, active=0, pkt_seq stays 7.
  - On re-enable, the next req carries seq 7.
- Sequence wrap: start with pkt_seq=255, ack once -> pkt_seq=0.
- Saturation: force 256 abandonments -> fail_cnt holds at 255.
- With BEACON_FAIL_CNT_EN undefined, repeat the abandonment case -> pkt_seq=1 and the fail_cnt port is absent.
